// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit layout, port numbering and credit constants
// used by the mapper receiver and the SRAM-to-NoC input controller.
package noc_pkg;

    localparam int INIT_CREDITS = 7;

    localparam int MAPPER0_PORT = 0;
    localparam int MAPPER1_PORT = 1;
    localparam int MAPPER2_PORT = 2;
    localparam int MAPPER3_PORT = 3;

    function automatic int dest_bits(input int num_ports);
        return $clog2(num_ports);
    endfunction

    function automatic int vc_bits(input int num_vcs);
        return (num_vcs > 1) ? $clog2(num_vcs) : 1;
    endfunction

    function automatic int flit_width(input int dw, input int db, input int vb);
        return 2 + dw + db + vb;
    endfunction

    // Flit is {valid, tail, dest, vc, data}, MSB first
    function automatic int flit_vc_lsb(input int dw);
        return dw;
    endfunction

    function automatic int flit_dest_lsb(input int dw, input int vb);
        return dw + vb;
    endfunction

    function automatic int flit_tail_bit(input int dw, input int db, input int vb);
        return dw + db + vb;
    endfunction

    function automatic int flit_valid_bit(input int dw, input int db, input int vb);
        return dw + db + vb + 1;
    endfunction

    localparam int FLIT_DATA_LSB  = 0;
    localparam int FLIT_VC_LSB    = flit_vc_lsb(32);
    localparam int FLIT_DEST_LSB  = flit_dest_lsb(32, 1);
    localparam int FLIT_TAIL_BIT  = flit_tail_bit(32, 2, 1);
    localparam int FLIT_VALID_BIT = flit_valid_bit(32, 2, 1);

endpackage

// File: rtl/noc_mapper_receiver_if.sv
// Flit ingress, word egress and credit return bundle of the mapper receiver.
// master drives flits/ready/credit enable, slave is the receiver.
interface noc_mapper_receiver_if #(
    parameter int FLIT_DATA_WIDTH     = 32,
    parameter int NUM_USER_RECV_PORTS = 4,
    parameter int NUM_VCS             = 1
);
    import noc_pkg::*;

    localparam int DEST_BITS = dest_bits(NUM_USER_RECV_PORTS);
    localparam int VC_BITS   = vc_bits(NUM_VCS);
    localparam int FLIT_W    = flit_width(FLIT_DATA_WIDTH, DEST_BITS, VC_BITS);

    logic [FLIT_W-1:0]          flit_in;
    logic [FLIT_DATA_WIDTH-1:0] word_data;
    logic                       word_last;
    logic                       word_valid;
    logic                       word_ready;
    logic                       en_send_credit;
    logic [VC_BITS:0]           send_credit;

    modport master (
        output flit_in,
        output word_ready,
        output en_send_credit,
        input  word_data,
        input  word_last,
        input  word_valid,
        input  send_credit
    );

    modport slave (
        input  flit_in,
        input  word_ready,
        input  en_send_credit,
        output word_data,
        output word_last,
        output word_valid,
        output send_credit
    );

endinterface

// File: rtl/noc_rx_fifo.sv
// Synchronous payload FIFO with a fall-through read port; the head entry is
// visible combinationally and reads as zero while the FIFO is empty.
module noc_rx_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      cnt;
    logic             do_push;
    logic             do_pop;

    assign empty   = (cnt == '0);
    assign full    = (cnt == (AW+1)'(DEPTH));
    assign count   = cnt;
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Storage carries no reset; emptiness masks stale contents
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/noc_mapper_receiver.sv
// Mapper-side NoC ejection: header strip, payload buffering, credit return,
// packet counting and sticky error flags.
module noc_mapper_receiver
    import noc_pkg::*;
#(
    parameter int FLIT_DATA_WIDTH     = 32,
    parameter int NUM_USER_RECV_PORTS = 4,
    parameter int NUM_VCS             = 1,
    parameter int MY_PORT             = MAPPER0_PORT,
    parameter int FIFO_DEPTH          = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    noc_mapper_receiver_if.slave bus,
    output logic [15:0]          pkt_count,
    output logic                 err_dest,
    output logic                 err_overflow
);

    localparam int DB        = dest_bits(NUM_USER_RECV_PORTS);
    localparam int VB        = vc_bits(NUM_VCS);
    localparam int VALID_BIT = flit_valid_bit(FLIT_DATA_WIDTH, DB, VB);
    localparam int TAIL_BIT  = flit_tail_bit(FLIT_DATA_WIDTH, DB, VB);
    localparam int DEST_LSB  = flit_dest_lsb(FLIT_DATA_WIDTH, VB);
    localparam int VC_LSB    = flit_vc_lsb(FLIT_DATA_WIDTH);
    localparam int BL_W      = $clog2(FIFO_DEPTH) + 2;
    localparam int CW        = $clog2(FIFO_DEPTH) + 1;

    localparam logic [DB-1:0] MY_DEST = DB'(MY_PORT);
    localparam logic [BL_W:0] BL_CAP  = {1'b0, {BL_W{1'b1}}};

    logic [1:0] rst_sync;
    logic       rst_int;

    // Assert immediately, release two clean edges after RST drops
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) rst_sync <= 2'b11;
        else     rst_sync <= {rst_sync[0], 1'b0};
    end

    assign rst_int = rst_sync[1];

    logic                       f_valid;
    logic                       f_tail;
    logic [DB-1:0]              f_dest;
    logic [FLIT_DATA_WIDTH-1:0] f_data;
    logic [VB-1:0]              unused_vc;
    logic                       dest_ok;

    assign f_valid   = bus.flit_in[VALID_BIT];
    assign f_tail    = bus.flit_in[TAIL_BIT];
    assign f_dest    = bus.flit_in[DEST_LSB +: DB];
    assign unused_vc = bus.flit_in[VC_LSB +: VB];
    assign f_data    = bus.flit_in[FLIT_DATA_LSB +: FLIT_DATA_WIDTH];
    assign dest_ok   = (f_dest == MY_DEST);

    logic                       fifo_full;
    logic                       fifo_empty;
    logic [CW-1:0]              unused_count;
    logic [FLIT_DATA_WIDTH:0]   fifo_rdata;
    logic                       push;
    logic                       pop;
    logic                       drop_dest;
    logic                       drop_ovf;

    assign pop       = bus.word_valid && bus.word_ready;
    assign push      = f_valid && dest_ok && (!fifo_full || pop);
    assign drop_dest = f_valid && !dest_ok;
    assign drop_ovf  = f_valid && dest_ok && fifo_full && !pop;

    noc_rx_fifo #(
        .WIDTH (FLIT_DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst   (rst_int),
        .push  (push),
        .pop   (pop),
        .wdata ({f_tail, f_data}),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (unused_count)
    );

    assign bus.word_valid = !fifo_empty;
    assign bus.word_data  = fifo_rdata[FLIT_DATA_WIDTH-1:0];
    assign bus.word_last  = fifo_rdata[FLIT_DATA_WIDTH];

    logic [BL_W-1:0] backlog;
    logic [BL_W-1:0] backlog_next;
    logic [BL_W:0]   bl_sum;
    logic            emit;
    logic [VB:0]     credit_q;

    // A mismatched flit still consumed a sender credit, so it is owed back
    always_comb begin
        emit   = bus.en_send_credit &&
                 ((backlog != '0) || pop || drop_dest);
        bl_sum = {1'b0, backlog}
               + (BL_W+1)'(pop)
               + (BL_W+1)'(drop_dest)
               - (BL_W+1)'(emit);
        backlog_next = (bl_sum > BL_CAP) ? BL_CAP[BL_W-1:0]
                                         : bl_sum[BL_W-1:0];
    end

    always_ff @(posedge CLK or posedge rst_int) begin
        if (rst_int) begin
            backlog      <= '0;
            credit_q     <= '0;
            pkt_count    <= '0;
            err_dest     <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            backlog  <= backlog_next;
            credit_q <= {emit, {VB{1'b0}}};
            if (pop && bus.word_last) pkt_count <= pkt_count + 16'd1;
            if (drop_dest) err_dest <= 1'b1;
            if (drop_ovf)  err_overflow <= 1'b1;
        end
    end

    assign bus.send_credit = credit_q;

endmodule

// File: tb/tb_noc_mapper_receiver.sv
// Scenario bench for noc_mapper_receiver: a word queue holds the expected
// FIFO contents and is popped as the mapper side consumes words.
module tb_noc_mapper_receiver;
    import noc_pkg::*;

    logic        CLK = 1'b0;
    logic        RST;
    logic [15:0] pkt_count;
    logic        err_dest;
    logic        err_overflow;

    int checks   = 0;
    int failures = 0;

    logic [32:0] q[$];

    noc_mapper_receiver_if #(
        .FLIT_DATA_WIDTH     (32),
        .NUM_USER_RECV_PORTS (4),
        .NUM_VCS             (1)
    ) bus ();

    noc_mapper_receiver #(
        .FLIT_DATA_WIDTH     (32),
        .NUM_USER_RECV_PORTS (4),
        .NUM_VCS             (1),
        .MY_PORT             (0),
        .FIFO_DEPTH          (8)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .bus          (bus),
        .pkt_count    (pkt_count),
        .err_dest     (err_dest),
        .err_overflow (err_overflow)
    );

    always #5 CLK = ~CLK;

    function automatic logic [36:0] mk(input logic tail,
                                       input logic [1:0] dest,
                                       input logic [31:0] data);
        return {1'b1, tail, dest, 1'b0, data};
    endfunction

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST = 1'b1;
        bus.flit_in = '0;
        bus.word_ready = 1'b0;
        bus.en_send_credit = 1'b0;
        q.delete();
        repeat (2) step();
        RST = 1'b0;
        repeat (3) step();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus.word_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_valid got=%b exp=0", bus.word_valid);
        end
        checks++;
        if (bus.word_data !== 32'h0) begin
            failures++;
            $display("FAIL reset_data got=%h exp=0", bus.word_data);
        end
        checks++;
        if (bus.word_last !== 1'b0) begin
            failures++;
            $display("FAIL reset_last got=%b exp=0", bus.word_last);
        end
        checks++;
        if (bus.send_credit !== 2'b00) begin
            failures++;
            $display("FAIL reset_credit got=%b exp=00", bus.send_credit);
        end
        checks++;
        if (pkt_count !== 16'd0) begin
            failures++;
            $display("FAIL reset_pkt got=%0d exp=0", pkt_count);
        end
        checks++;
        if ({err_dest, err_overflow} !== 2'b00) begin
            failures++;
            $display("FAIL reset_err got=%b exp=00", {err_dest, err_overflow});
        end
    endtask

    task automatic test_basic_packet();
        logic exp_cred;
        logic [31:0] d;
        do_reset();
        exp_cred = 1'b0;
        bus.word_ready = 1'b1;
        bus.en_send_credit = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i < 3) begin
                d = 32'(32'hA1 + i);
                bus.flit_in = mk(i == 2, 2'd0, d);
                q.push_back({i == 2, d});
            end else begin
                bus.flit_in = '0;
            end
            step();
            checks++;
            if (bus.send_credit !== {exp_cred, 1'b0}) begin
                failures++;
                $display("FAIL basic_credit step=%0d got=%b exp=%b",
                         i, bus.send_credit, {exp_cred, 1'b0});
            end
            checks++;
            if (bus.word_valid !== (q.size() != 0)) begin
                failures++;
                $display("FAIL basic_valid step=%0d got=%b exp=%b",
                         i, bus.word_valid, q.size() != 0);
            end
            exp_cred = 1'b0;
            if (q.size() != 0) begin
                checks++;
                if ({bus.word_last, bus.word_data} !== q[0]) begin
                    failures++;
                    $display("FAIL basic_word step=%0d got=%h exp=%h",
                             i, {bus.word_last, bus.word_data}, q[0]);
                end
                void'(q.pop_front());
                exp_cred = 1'b1;
            end
        end
        checks++;
        if (pkt_count !== 16'd1) begin
            failures++;
            $display("FAIL basic_pkt got=%0d exp=1", pkt_count);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] d;
        do_reset();
        bus.word_ready = 1'b0;
        bus.en_send_credit = 1'b1;
        for (int i = 0; i < 8; i++) begin
            d = 32'(32'hB0 + i);
            bus.flit_in = mk(1'b0, 2'd0, d);
            q.push_back({1'b0, d});
            step();
            checks++;
            if ({bus.send_credit, err_overflow, err_dest} !== 4'b0000) begin
                failures++;
                $display("FAIL fill_quiet step=%0d got=%b exp=0000",
                         i, {bus.send_credit, err_overflow, err_dest});
            end
        end
        bus.flit_in = '0;
        checks++;
        if ({bus.word_valid, bus.word_data} !== {1'b1, 32'hB0}) begin
            failures++;
            $display("FAIL fill_head got=%h exp=1_000000b0",
                     {bus.word_valid, bus.word_data});
        end
        // Full FIFO: push and pop together
        bus.flit_in = mk(1'b0, 2'd0, 32'hC0);
        bus.word_ready = 1'b1;
        q.push_back({1'b0, 32'hC0});
        void'(q.pop_front());
        step();
        bus.flit_in = '0;
        bus.word_ready = 1'b0;
        checks++;
        if (err_overflow !== 1'b0) begin
            failures++;
            $display("FAIL full_pushpop_err got=%b exp=0", err_overflow);
        end
        bus.flit_in = mk(1'b1, 2'd0, 32'hBF);
        step();
        bus.flit_in = '0;
        checks++;
        if (err_overflow !== 1'b1) begin
            failures++;
            $display("FAIL overflow_err got=%b exp=1", err_overflow);
        end
        bus.word_ready = 1'b1;
        for (int n = 0; n < 8; n++) begin
            checks++;
            if (q.size() == 0) begin
                failures++;
                $display("FAIL drain_queue n=%0d got=empty exp=word", n);
                break;
            end
            if (bus.word_valid !== 1'b1 ||
                {bus.word_last, bus.word_data} !== q[0]) begin
                failures++;
                $display("FAIL drain_word n=%0d got=%b_%h exp=1_%h",
                         n, bus.word_valid,
                         {bus.word_last, bus.word_data}, q[0]);
            end
            void'(q.pop_front());
            step();
        end
        bus.word_ready = 1'b0;
        checks++;
        if (bus.word_valid !== 1'b0) begin
            failures++;
            $display("FAIL drain_empty got=%b exp=0", bus.word_valid);
        end
        checks++;
        if (err_overflow !== 1'b1) begin
            failures++;
            $display("FAIL overflow_sticky got=%b exp=1", err_overflow);
        end
    endtask

    task automatic test_dest_mismatch();
        do_reset();
        bus.word_ready = 1'b1;
        bus.en_send_credit = 1'b1;
        bus.flit_in = mk(1'b0, 2'd1, 32'hDD);
        step();
        bus.flit_in = '0;
        checks++;
        if (err_dest !== 1'b1) begin
            failures++;
            $display("FAIL dest_err got=%b exp=1", err_dest);
        end
        checks++;
        if (bus.word_valid !== 1'b0) begin
            failures++;
            $display("FAIL dest_buffered got=%b exp=0", bus.word_valid);
        end
        checks++;
        if (bus.send_credit !== 2'b10) begin
            failures++;
            $display("FAIL dest_credit got=%b exp=10", bus.send_credit);
        end
        step();
        checks++;
        if ({bus.send_credit, err_dest, err_overflow} !== 4'b0010) begin
            failures++;
            $display("FAIL dest_after got=%b exp=0010",
                     {bus.send_credit, err_dest, err_overflow});
        end
    endtask

    task automatic test_credit_backlog();
        logic [31:0] d;
        do_reset();
        bus.word_ready = 1'b0;
        bus.en_send_credit = 1'b0;
        for (int i = 0; i < 5; i++) begin
            d = 32'(32'hE0 + i);
            bus.flit_in = mk(i == 4, 2'd0, d);
            q.push_back({i == 4, d});
            step();
        end
        bus.flit_in = '0;
        bus.word_ready = 1'b1;
        for (int n = 0; n < 5; n++) begin
            checks++;
            if (q.size() == 0 || bus.word_valid !== 1'b1 ||
                {bus.word_last, bus.word_data} !== q[0]) begin
                failures++;
                $display("FAIL backlog_word n=%0d got=%h exp=%h", n,
                         {bus.word_last, bus.word_data},
                         (q.size() != 0) ? q[0] : 33'h0);
            end
            if (q.size() != 0) void'(q.pop_front());
            step();
            checks++;
            if (bus.send_credit !== 2'b00) begin
                failures++;
                $display("FAIL backlog_held n=%0d got=%b exp=00",
                         n, bus.send_credit);
            end
        end
        bus.word_ready = 1'b0;
        checks++;
        if ({bus.word_valid, pkt_count} !== {1'b0, 16'd1}) begin
            failures++;
            $display("FAIL backlog_drained got=%h exp=0_0001",
                     {bus.word_valid, pkt_count});
        end
        bus.en_send_credit = 1'b1;
        for (int n = 0; n < 8; n++) begin
            step();
            checks++;
            if (bus.send_credit[1] !== (n < 5)) begin
                failures++;
                $display("FAIL backlog_release n=%0d got=%b exp=%b",
                         n, bus.send_credit[1], n < 5);
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        bus.word_ready = 1'b0;
        bus.en_send_credit = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus.flit_in = mk(1'b0, 2'd0, 32'(32'hF0 + i));
            step();
        end
        bus.flit_in = '0;
        bus.word_ready = 1'b1;
        repeat (2) step();
        bus.word_ready = 1'b0;
        checks++;
        if ({bus.word_valid, bus.word_data} !== {1'b1, 32'hF2}) begin
            failures++;
            $display("FAIL midpkt_head got=%h exp=1_000000f2",
                     {bus.word_valid, bus.word_data});
        end
        #2;
        RST = 1'b1;
        #1;
        checks++;
        if ({bus.word_valid, bus.word_last, bus.word_data} !== 34'h0) begin
            failures++;
            $display("FAIL async_word got=%h exp=0",
                     {bus.word_valid, bus.word_last, bus.word_data});
        end
        checks++;
        if ({bus.send_credit, pkt_count, err_dest, err_overflow} !== 20'h0) begin
            failures++;
            $display("FAIL async_status got=%h exp=0",
                     {bus.send_credit, pkt_count, err_dest, err_overflow});
        end
        q.delete();
        bus.en_send_credit = 1'b1;
        bus.word_ready = 1'b1;
        repeat (2) step();
        #3;
        RST = 1'b0;
        for (int n = 0; n < 10; n++) begin
            step();
            checks++;
            if ({bus.send_credit, bus.word_valid} !== 3'b000) begin
                failures++;
                $display("FAIL post_reset n=%0d got=%b exp=000",
                         n, {bus.send_credit, bus.word_valid});
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic_packet();
        test_overflow();
        test_dest_mismatch();
        test_credit_backlog();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/noc_mapper_receiver.md
Name: noc_mapper_receiver

Overview:
- Mapper-side NoC ejection stage, directly downstream of the SRAM-to-NoC input controller through the NoC.
- Accepts flits addressed to one mapper port and strips the flit header.
- Buffers the payload in a credit-matched FIFO and presents words with valid/ready and a packet-last flag to the mapper core.
- Returns one credit per consumed word to the upstream controller's get_credit_mapperN input.

Parameters:
FLIT_DATA_WIDTH, 32, payload bits per flit.
NUM_USER_RECV_PORTS, 4, NoC user ports; DEST_BITS = $clog2(NUM_USER_RECV_PORTS).
NUM_VCS, 1, virtual channels; VC_BITS = (NUM_VCS>1) ? $clog2(NUM_VCS) : 1.
MY_PORT, 0, this mapper's destination port number.
FIFO_DEPTH, 8, payload buffer entries (power of 2, >= 7 = upstream initial credit count).

Ports:
CLK  in  1  clock, rising edge.
RST  in  1  asynchronous, active-high reset.
flit_in  in  2+FLIT_DATA_WIDTH+DEST_BITS+VC_BITS  {valid, tail, dest, vc, data}, MSB first.
word_data  out  FLIT_DATA_WIDTH  payload at FIFO head.
word_last  out  1  head word is a packet tail.
word_valid  out  1  FIFO non-empty.
word_ready  in  1  mapper consumes head when word_valid && word_ready.
en_send_credit  in  1  upstream permits credit return this cycle.
send_credit  out  VC_BITS+1  {credit_valid, vc}; vc is always 0.
pkt_count  out  16  number of tail words consumed.
err_dest  out  1  sticky: flit with dest != MY_PORT was received.
err_overflow  out  1  sticky: flit arrived while FIFO full with no simultaneous pop.

Behaviour:
- Reset (async assert, sync release): FIFO empty, word_valid=0, word_data=0, word_last=0, send_credit=0, credit backlog=0, pkt_count=0, err_dest=0, err_overflow=0. Reset mid-packet discards all buffered words and owed credits.
- Push:
  - A flit with valid=1, dest==MY_PORT, and either count<FIFO_DEPTH or a pop in the same cycle is written as {tail,data} at the edge.
  - word_valid rises the following cycle: 1-cycle latency from flit_in to head.
  - The vc field is ignored.
- Dest mismatch: the flit is dropped and err_dest is set. The backlog is still incremented by 1, because the sender spent a credit.
- Overflow: the flit is dropped and err_overflow is set. No credit is returned.
- Pop: when word_valid && word_ready at the edge, the head advances. word_data/word_last show the next entry combinationally from the FIFO read port. If word_last was 1 at pop, pkt_count increments and wraps at 16'hFFFF->0.
- Credit return:
  - backlog_next = backlog + pop + mismatch_drop - emit.
  - emit = en_send_credit && (backlog>0 || pop || mismatch_drop).
  - send_credit is registered: {emit,0} appears the cycle after the causing event when en_send_credit is high.
  - At most one credit is emitted per cycle.
  - The backlog counter is $clog2(FIFO_DEPTH)+2 bits wide and saturates, never wrapping.
  - While en_send_credit=0, credits accumulate in the backlog and drain one per cycle once it rises.
- Simultaneous push+pop when empty: the pushed word becomes head next cycle. The pop is not possible in the same cycle because word_valid=0.
- Simultaneous push+pop when full: both occur and count is unchanged.
- The sticky errors clear only on reset.

Decomposition:
- Shared package noc_pkg:
  - DEST_BITS and VC_BITS derivation functions.
  - Flit field offsets: FLIT_VALID_BIT, FLIT_TAIL_BIT, FLIT_DEST_LSB, FLIT_VC_LSB, FLIT_DATA_LSB.
  - MAPPERn_PORT constants.
  - The initial credit constant 7, which is also used by the input controller.
- Sub-module noc_rx_fifo: synchronous FIFO, width FLIT_DATA_WIDTH+1, parameter DEPTH, with push/pop/full/empty/count outputs and a fall-through read port.
- Top level contains the flit decode, drop/error logic, credit backlog and pkt_count.

Test Plan:
- Reset, then send 3 flits to port 0 (data 0xA1,0xA2, then 0xA3 with tail=1) with word_ready=1 and en_send_credit=1 -> words appear in order, each 1 cycle after injection; word_last=1 only on 0xA3; send_credit valid 3 times, each 1 cycle after its pop; pkt_count=1.
- word_ready=0, inject 8 flits -> word_valid=1, no credits emitted, no error; inject a 9th flit -> dropped, err_overflow=1, FIFO still holds the first 8 words in order.
- With the FIFO full, push and pop in the same cycle -> count stays 8 and err_overflow stays 0.
- Inject a flit with dest=1 while MY_PORT=0 -> not buffered, err_dest=1, one credit returned the next cycle.
- en_send_credit=0 while popping 5 words -> send_credit stays 0; raise en_send_credit -> exactly 5 consecutive cycles of credit_valid=1.
- Assert RST asynchronously mid-packet with 4 words buffered and backlog 2 -> outputs go to their reset values immediately; no credits are emitted after release.
